// File: rtl/sd_cmd_phy.sv
// sd_cmd_phy: SD CMD-line transceiver; divides wb_clk into sd_clock, sends a CRC7 command frame, captures 48/136-bit responses.
// Define SD_CMD_NCC_EN to hold busy for an 8-clock NCC gap before done.
module sd_cmd_phy #(
   parameter int RESP_TIMEOUT = 64,
   parameter int DIV_W        = 16
) (
   input  logic             wb_clk,
   input  logic             wb_rst,
   input  logic [DIV_W-1:0] clk_div,
   input  logic             start,
   input  logic [5:0]       cmd_index,
   input  logic [31:0]      cmd_arg,
   input  logic [1:0]       resp_type,
   output logic             busy,
   output logic             done,
   output logic             timeout,
   output logic             crc_err,
   output logic [5:0]       resp_index,
   output logic [119:0]     resp_data,
   output logic             sd_clock,
   output logic             cmd_o,
   output logic             cmd_oe,
   input  logic             cmd_i
);
   localparam int CW = $clog2(((RESP_TIMEOUT > 136) ? RESP_TIMEOUT : 136) + 1);
`ifdef SD_CMD_NCC_EN
   typedef enum logic [2:0] {IDLE, SEND, WAIT_RESP, RECV, GAP, DONE} state_t;
   localparam state_t POST = GAP;
`else
   typedef enum logic [2:0] {IDLE, SEND, WAIT_RESP, RECV, DONE} state_t;
   localparam state_t POST = DONE;
`endif
   function automatic logic [6:0] crc7_step(input logic [6:0] c, input logic b);
      return {c[5:0], 1'b0} ^ ((b ^ c[6]) ? 7'h09 : 7'h00);
   endfunction
   function automatic logic [6:0] crc7_40(input logic [39:0] v);
      logic [6:0] c;
      c = '0;
      for (int i = 39; i >= 0; i--) c = crc7_step(c, v[i]);
      return c;
   endfunction
   state_t           state_q;
   logic [DIV_W-1:0] cnt_q, div_q;
   logic             sd_clk_q, cmd_o_q, cmd_oe_q, busy_q, done_q, to_q, crc_err_q;
   logic [5:0]       idx_q;
   logic [119:0]     data_q;
   logic [CW-1:0]    bcnt_q;
   logic [6:0]       crc_q;
   logic [132:0]     rx_q;
   logic [47:0]      tx_q;
   logic [1:0]       rtype_q;
   logic             tc, fall_evt, rise_evt, accept, is_long, last_bit, crc_on, bad;
   logic [39:0]      hdr;
   logic [133:0]     rx_d;
   logic [CW-1:0]    n_d;
   logic [6:0]       crc_d;
   assign tc       = cnt_q == div_q;
   assign fall_evt = tc && sd_clk_q;
   assign rise_evt = tc && !sd_clk_q;
   assign accept   = start && (state_q == IDLE || state_q == DONE);
   assign hdr      = {2'b01, cmd_index, cmd_arg};
   assign rx_d     = {rx_q, cmd_i};
   assign n_d      = bcnt_q + 1'b1;
   assign is_long  = rtype_q == 2'd2;
   assign last_bit = n_d == (is_long ? CW'(136) : CW'(48));
   // R2 skips its 8 header bits in the CRC; short frames cover the first 40 bits
   assign crc_on   = is_long ? (n_d > CW'(8) && n_d <= CW'(128)) : (n_d <= CW'(40));
   assign crc_d    = crc_on ? crc7_step(crc_q, cmd_i) : crc_q;
   assign bad      = (rtype_q != 2'd3 && crc_q != rx_d[7:1]) || !rx_d[0];
   always_ff @(posedge wb_clk) begin
      if (!wb_rst) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         div_q     <= '0;
         sd_clk_q  <= 1'b0;
         cmd_o_q   <= 1'b1;
         cmd_oe_q  <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         to_q      <= 1'b0;
         crc_err_q <= 1'b0;
         idx_q     <= '0;
         data_q    <= '0;
         bcnt_q    <= '0;
         crc_q     <= '0;
         rx_q      <= '0;
         tx_q      <= '0;
         rtype_q   <= '0;
      end else begin
         cnt_q  <= tc ? '0 : cnt_q + 1'b1;
         done_q <= 1'b0;
         if (tc) begin
            sd_clk_q <= ~sd_clk_q;
            div_q    <= clk_div;
         end
         case (state_q)
            IDLE, DONE: begin
               state_q <= IDLE;
               if (accept) begin
                  tx_q      <= {hdr, crc7_40(hdr), 1'b1};
                  rtype_q   <= resp_type;
                  to_q      <= 1'b0;
                  crc_err_q <= 1'b0;
                  busy_q    <= 1'b1;
                  bcnt_q    <= '0;
                  state_q   <= SEND;
               end
            end
            SEND: if (fall_evt) begin
               if (bcnt_q == CW'(48)) begin
                  cmd_oe_q <= 1'b0;
                  cmd_o_q  <= 1'b1;
                  bcnt_q   <= '0;
                  state_q  <= (rtype_q == 2'd0) ? POST : WAIT_RESP;
                  done_q   <= rtype_q == 2'd0 && POST == DONE;
                  busy_q   <= !(rtype_q == 2'd0 && POST == DONE);
               end else begin
                  cmd_oe_q <= 1'b1;
                  cmd_o_q  <= tx_q[47];
                  tx_q     <= {tx_q[46:0], 1'b0};
                  bcnt_q   <= n_d;
               end
            end
            WAIT_RESP: if (rise_evt) begin
               if (!cmd_i) begin
                  state_q <= RECV;
                  bcnt_q  <= CW'(1);
                  rx_q    <= '0;
                  crc_q   <= '0;
               end else if (n_d == CW'(RESP_TIMEOUT)) begin
                  to_q    <= 1'b1;
                  done_q  <= 1'b1;
                  busy_q  <= 1'b0;
                  state_q <= DONE;
               end else begin
                  bcnt_q <= n_d;
               end
            end
            RECV: if (rise_evt) begin
               rx_q   <= rx_d[132:0];
               crc_q  <= crc_d;
               bcnt_q <= n_d;
               if (last_bit) begin
                  idx_q     <= is_long ? rx_d[133:128] : rx_d[45:40];
                  data_q    <= is_long ? rx_d[127:8] : {88'b0, rx_d[39:8]};
                  crc_err_q <= bad;
                  bcnt_q    <= '0;
                  state_q   <= POST;
                  done_q    <= POST == DONE;
                  busy_q    <= POST != DONE;
               end
            end
`ifdef SD_CMD_NCC_EN
            GAP: if (rise_evt) begin
               bcnt_q <= n_d;
               if (n_d == CW'(8)) begin
                  state_q <= DONE;
                  done_q  <= 1'b1;
                  busy_q  <= 1'b0;
               end
            end
`endif
            default: state_q <= IDLE;
         endcase
      end
   end
   assign busy       = busy_q;
   assign done       = done_q;
   assign timeout    = to_q;
   assign crc_err    = crc_err_q;
   assign resp_index = idx_q;
   assign resp_data  = data_q;
   assign sd_clock   = sd_clk_q;
   assign cmd_o      = cmd_o_q;
   assign cmd_oe     = cmd_oe_q;
endmodule
